// File: rtl/ps2_keyboard_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ps2_keyboard_fifo_if                                         |
// | Purpose  : PS/2 pins plus the host-side keycode/irq/status bundle.      |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface ps2_keyboard_fifo_if;
  logic       device_clock;
  logic       device_data;
  logic       clear_keycode;
  logic       irq;
  logic [7:0] keycode;
  logic       frame_error;
  logic       overflow;

  modport master (
    output device_clock, device_data, clear_keycode,
    input  irq, keycode, frame_error, overflow
  );

  modport slave (
    input  device_clock, device_data, clear_keycode,
    output irq, keycode, frame_error, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ps2_keyboard_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ps2_keyboard_fifo                                            |
// | Purpose  : PS/2 device-to-host receiver with scancode buffering.        |
// |            Define PS2KB_FIFO_EN for a 2^fifo_depth_log2 byte FIFO,      |
// |            otherwise a single-byte holding register is used.           |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module ps2_keyboard_fifo #(
  parameter logic [15:0] over_time       = 16'd1000,
  parameter int          fifo_depth_log2 = 3
) (
  input  logic                clock,
  input  logic                reset,
  ps2_keyboard_fifo_if.slave  kb
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_clk_s1, r_clk_s2, r_clk_s3;
  logic        r_dat_s1, r_dat_s2;
  logic [9:0]  r_shift;
  logic [3:0]  r_count;
  logic [15:0] r_timer;
  logic        r_frame_ok;
  logic        r_frame_error;
  logic        r_overflow;
  logic        r_irq;
  logic [7:0]  r_keycode;

  logic        w_fall;
  logic        w_bit;
  logic [9:0]  w_next_shift;
  logic        w_next_ok;
  logic        w_push;
  logic        w_pop;
  logic        w_accept;
  logic        w_nonempty;
  logic [7:0]  w_head;

  assign w_fall       = ~r_clk_s2 & r_clk_s3;
  assign w_bit        = r_dat_s2;
  assign w_next_shift = {w_bit, r_shift[9:1]};
  // Odd parity over data+parity, and the stop bit must be high.
  assign w_next_ok    = (^w_next_shift[8:0]) & w_next_shift[9];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= kb.device_clock;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= kb.device_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer <= 16'd0;
    end else if (w_fall) begin
      r_timer <= 16'd0;
    end else if (r_state == S_RECV && r_timer != 16'hFFFF) begin
      r_timer <= r_timer + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_shift       <= 10'd0;
      r_count       <= 4'd0;
      r_frame_ok    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_frame_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall && !w_bit) begin
            r_state <= S_RECV;
            r_count <= 4'd0;
          end
        end
        S_RECV: begin
          if (w_fall) begin
            r_shift <= w_next_shift;
            r_count <= r_count + 4'd1;
            if (r_count == 4'd9) begin
              r_state       <= S_DONE;
              r_frame_ok    <= w_next_ok;
              r_frame_error <= ~w_next_ok;
            end
          end else if (r_timer == over_time - 16'd1) begin
            r_state       <= S_IDLE;
            r_frame_error <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_push = (r_state == S_DONE) && r_frame_ok;
  assign w_pop  = !r_irq && !kb.clear_keycode && w_nonempty;

`ifdef PS2KB_FIFO_EN
  localparam int DEPTH = 1 << fifo_depth_log2;

  logic [7:0]                 r_mem [0:DEPTH-1];
  logic [fifo_depth_log2-1:0] r_wr;
  logic [fifo_depth_log2-1:0] r_rd;
  logic [fifo_depth_log2:0]   r_cnt;
  logic                       w_full;

  assign w_full     = (r_cnt == (fifo_depth_log2 + 1)'(DEPTH));
  assign w_nonempty = (r_cnt != '0);
  assign w_head     = r_mem[r_rd];
  // A pop in the same cycle frees the slot the push is about to use.
  assign w_accept   = w_push && (!w_full || w_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) r_wr <= r_wr + 1'b1;
      if (w_pop)    r_rd <= r_rd + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) r_mem[r_wr] <= r_shift[7:0];
  end
`else
  logic [7:0] r_hold;
  logic       r_hold_valid;

  assign w_nonempty = r_hold_valid;
  assign w_head     = r_hold;
  // Single-entry mode: a byte still presented on keycode also counts as occupying the buffer.
  assign w_accept   = w_push && !r_hold_valid && !r_irq;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold       <= 8'h00;
      r_hold_valid <= 1'b0;
    end else begin
      if (w_pop) r_hold_valid <= 1'b0;
      if (w_accept) begin
        r_hold       <= r_shift[7:0];
        r_hold_valid <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_keycode  <= 8'h00;
      r_irq      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && !w_accept;
      if (kb.clear_keycode) begin
        r_keycode <= 8'h00;
        r_irq     <= 1'b0;
      end else if (w_pop) begin
        r_keycode <= w_head;
        r_irq     <= 1'b1;
      end
    end
  end

  assign kb.keycode     = r_keycode;
  assign kb.irq         = r_irq;
  assign kb.frame_error = r_frame_error;
  assign kb.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_ps2_keyboard_fifo                                         |
// | Purpose  : Randomised PS/2 frame stimulus against a queue-based model.  |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_ps2_keyboard_fifo;

  localparam int HALF      = 5;
  localparam int FIFO_LOG2 = 3;
`ifdef PS2KB_FIFO_EN
  localparam int CAP = 1 << FIFO_LOG2;
`else
  localparam int CAP = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  ps2_keyboard_fifo_if kb();

  ps2_keyboard_fifo #(
    .over_time       (16'd1000),
    .fifo_depth_log2 (FIFO_LOG2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kb    (kb)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_err    = 0;
  int n_ovf    = 0;

  // Reference model: buffered bytes, the presented byte and expected pulse totals.
  logic [7:0] q[$];
  bit         pres;
  logic [7:0] pres_b;
  bit         clr;
  int         exp_err;
  int         exp_ovf;

  always @(negedge clock) begin
    if (kb.frame_error === 1'b1) n_err++;
    if (kb.overflow === 1'b1)    n_ovf++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_settle();
    if (clr) pres = 1'b0;
    else if (!pres && q.size() > 0) begin
      pres_b = q.pop_front();
      pres   = 1'b1;
    end
  endfunction

  function automatic void model_push(input logic [7:0] b);
    bit fits;
    if (CAP > 1) fits = (q.size() < CAP);
    else         fits = (q.size() == 0) && !pres;
    if (fits) q.push_back(b);
    else      exp_ovf++;
  endfunction

  task automatic compare_all(input string tag);
    check_val({tag, "_keycode"}, {24'd0, kb.keycode}, pres ? {24'd0, pres_b} : 32'd0);
    check_val({tag, "_irq"}, {31'd0, kb.irq}, {31'd0, pres});
    check_val({tag, "_err"}, n_err, exp_err);
    check_val({tag, "_ovf"}, n_ovf, exp_ovf);
  endtask

  // Sends the first nbits bits of a frame (11 = full frame), driving pins right after a negedge.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit lat);
    logic [10:0] bits;
    bits = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kb.device_data = bits[i];
      repeat (HALF) @(negedge clock);
      kb.device_clock = 1'b0;
      if (lat && i == 10) begin
        repeat (4) @(negedge clock);
        check_val("lat_early_irq", {31'd0, kb.irq}, 32'd0);
        @(negedge clock);
        check_val("lat_irq", {31'd0, kb.irq}, 32'd1);
        check_val("lat_keycode", {24'd0, kb.keycode}, {24'd0, b});
      end else begin
        repeat (HALF) @(negedge clock);
      end
      kb.device_clock = 1'b1;
    end
    kb.device_data = 1'b1;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic good_frame(input logic [7:0] b, input string tag);
    send_frame(b, 1'b0, 1'b0, 11, 1'b0);
    repeat (8) @(negedge clock);
    model_push(b);
    model_settle();
    compare_all(tag);
  endtask

  task automatic pulse_clear(input string tag);
    kb.clear_keycode = 1'b1;
    clr = 1'b1;
    @(negedge clock);
    model_settle();
    check_val({tag, "_clr_keycode"}, {24'd0, kb.keycode}, 32'd0);
    check_val({tag, "_clr_irq"}, {31'd0, kb.irq}, 32'd0);
    kb.clear_keycode = 1'b0;
    clr = 1'b0;
    repeat (4) @(negedge clock);
    model_settle();
    compare_all(tag);
  endtask

  initial begin
    kb.device_clock  = 1'b1;
    kb.device_data   = 1'b1;
    kb.clear_keycode = 1'b0;
    pres = 1'b0; pres_b = 8'h00; clr = 1'b0; exp_err = 0; exp_ovf = 0;

    repeat (3) @(negedge clock);
    check_val("rst_keycode", {24'd0, kb.keycode}, 32'd0);
    check_val("rst_irq", {31'd0, kb.irq}, 32'd0);
    check_val("rst_ferr", {31'd0, kb.frame_error}, 32'd0);
    check_val("rst_ovf", {31'd0, kb.overflow}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Valid frame with exact latency, then clear.
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b1);
    repeat (8) @(negedge clock);
    model_push(8'h1C); model_settle();
    compare_all("valid_1c");
    pulse_clear("clear_1c");

    // Parity error.
    send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
    repeat (8) @(negedge clock);
    exp_err++;
    compare_all("parity_err");

    // Timeout after start + 4 bits, then a clean frame.
    send_frame(8'h00, 1'b0, 1'b0, 5, 1'b0);
    repeat (1100) @(negedge clock);
    exp_err++;
    compare_all("timeout");
    good_frame(8'h29, "after_timeout");
    pulse_clear("clear_29");

    // Nine bytes while clear is held, then drain.
    kb.clear_keycode = 1'b1; clr = 1'b1;
    for (int i = 1; i <= 9; i++) good_frame(8'(i), "burst");
    kb.clear_keycode = 1'b0; clr = 1'b0;
    repeat (4) @(negedge clock);
    model_settle();
    compare_all("drain_first");
    for (int i = 0; i < 8; i++) pulse_clear("drain");

    // Reset in the middle of a frame.
    send_frame(8'hFF, 1'b0, 1'b0, 5, 1'b0);
    reset = 1'b1;
    #1;
    check_val("midrst_keycode", {24'd0, kb.keycode}, 32'd0);
    check_val("midrst_irq", {31'd0, kb.irq}, 32'd0);
    q.delete(); pres = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    good_frame(8'h5A, "after_reset");
    pulse_clear("clear_5a");

    // Two bytes without clearing.
    good_frame(8'hAA, "hold_aa");
    good_frame(8'hBB, "hold_bb");
    pulse_clear("clear_aabb");
    pulse_clear("clear_aabb2");

    // Randomised mix of good, bad, truncated frames and clear activity.
    for (int it = 0; it < 40; it++) begin
      int         kind;
      logic [7:0] b;
      kind = int'($urandom_range(0, 10));
      b    = 8'($urandom);
      if (kind <= 5) begin
        good_frame(b, "rnd_good");
      end else if (kind == 6 || kind == 7) begin
        send_frame(b, kind == 6, kind == 7, 11, 1'b0);
        repeat (8) @(negedge clock);
        exp_err++;
        compare_all("rnd_bad");
      end else if (kind == 8) begin
        send_frame(b, 1'b0, 1'b0, int'($urandom_range(2, 10)), 1'b0);
        repeat (1100) @(negedge clock);
        exp_err++;
        compare_all("rnd_timeout");
      end else if (kind == 9) begin
        pulse_clear("rnd_clear");
      end else begin
        kb.clear_keycode = ~kb.clear_keycode;
        clr = kb.clear_keycode;
        repeat (4) @(negedge clock);
        model_settle();
        compare_all("rnd_level");
      end
    end
    kb.clear_keycode = 1'b0; clr = 1'b0;
    repeat (4) @(negedge clock);
    model_settle();
    compare_all("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
